// File: rtl/klp32_mem_pkg.sv
// Shared types and helpers for the KLP32 data-memory path: load/store width
// encodings, responder FSM states and access-legality checks.
package klp32_mem_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  localparam int unsigned CountW = 4;

  function automatic logic is_misaligned(logic [2:0] mode, logic [1:0] addr_lo);
    case (mode)
      LS_H, LS_HU: return addr_lo[0];
      LS_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned widths only make sense for loads.
  function automatic logic is_illegal(logic [2:0] mode, logic rw);
    case (mode)
      LS_B, LS_H, LS_W: return 1'b0;
      LS_BU, LS_HU:     return rw;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Byte-lane steering for RV32I loads and stores: store byte enables with
// replicated data, and load lane extraction with sign/zero extension.
module ls_lane_align
  import klp32_mem_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  always_comb begin
    st_be_o   = 4'b0000;
    st_data_o = st_data_i;
    ld_data_o = 32'h0;
    ld_shift  = ld_word_i >> {addr_lo_i, 3'b000};
    case (mode_i)
      LS_B: begin
        st_be_o   = 4'b0001 << addr_lo_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      end
      LS_BU: begin
        ld_data_o = {24'h0, ld_shift[7:0]};
      end
      LS_H: begin
        st_be_o   = 4'b0011 << addr_lo_i;
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      end
      LS_HU: begin
        ld_data_o = {16'h0, ld_shift[15:0]};
      end
      LS_W: begin
        st_be_o   = 4'b1111;
        ld_data_o = ld_word_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data responder: single outstanding load/store against an
// internal word RAM, answered after LATENCY wait states.
module data_mem_responder
  import klp32_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_mem_rw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_writedata,
  input  logic [2:0]  i_load_store_mode,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_mem_rdy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  mem_state_e        state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        mode_q, mode_d;
  logic              rw_q, rw_d;
  logic [31:0]       rword_q, rword_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // In IDLE the operands come straight from the inputs so LATENCY=0 can
  // access the RAM on the accepting edge.
  logic            in_idle;
  logic [31:0]     op_addr, op_wdata;
  logic [2:0]      op_mode;
  logic            op_rw, op_err, access, mem_we;
  logic [IdxW-1:0] op_idx;
  logic [31:0]     mem_rdata, st_data, ld_data;
  logic [3:0]      st_be;

  assign in_idle  = (state_q == IDLE);
  assign op_addr  = in_idle ? i_addr            : addr_q;
  assign op_wdata = in_idle ? i_writedata       : wdata_q;
  assign op_mode  = in_idle ? i_load_store_mode : mode_q;
  assign op_rw    = in_idle ? i_mem_rw          : rw_q;
  assign op_idx   = op_addr[IdxW+1:2];
  assign op_err   = ({2'b00, op_addr[31:2]} >= DEPTH) ||
                    is_misaligned(op_mode, op_addr[1:0]) ||
                    is_illegal(op_mode, op_rw);
  assign mem_rdata = mem[op_idx];

  ls_lane_align u_align (
    .mode_i    (op_mode),
    .addr_lo_i (op_addr[1:0]),
    .st_data_i (op_wdata),
    .ld_word_i (rword_q),
    .st_be_o   (st_be),
    .st_data_o (st_data),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mode_d      = mode_q;
    rw_d        = rw_q;
    rword_d     = rword_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d  = i_addr;
          wdata_d = i_writedata;
          mode_d  = i_load_store_mode;
          rw_d    = i_mem_rw;
          count_d = CountW'(LATENCY);
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        count_d = count_q - CountW'(1);
        if (count_q == CountW'(1)) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = op_err;
        rsp_rdata_d = (op_err || op_rw) ? 32'h0 : ld_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (access && !op_rw) begin
      rword_d = mem_rdata;
    end
  end

  // Reset also blocks the write so a dropped store never lands.
  assign mem_we = access && op_rw && !op_err && reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[op_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= '0;
      rw_q        <= 1'b0;
      rword_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      rw_q        <= rw_d;
      rword_q     <= rword_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = in_idle;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mem_rdy   = (in_idle && !i_req_valid) || (state_q == RESP);

endmodule
